data_mem_unit: RTL and testbench

Multi-cycle data-memory responder for the ARM-subset pipeline. It is the memory-side endpoint of the load/store control signals that the control unit decodes: enable, read/write and byte/word size. It services each request against an internal byte-wide RAM, one byte per cycle, in big-endian order. It reports completion with a one-cycle `done` pulse and holds `busy` high while an access is in flight.

---
 rtl/data_mem_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_data_mem_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// data_mem_unit
//
// Multi-cycle data-memory responder for the ARM-subset pipeline. It accepts a
// load/store request from the control unit and services it one byte per cycle
// against an internal byte-wide RAM, in big-endian lane order. A word takes
// four byte cycles and a byte takes one. Completion is signalled by a one-cycle
// `done` pulse. `busy` is high from acceptance until `done` falls.
//
// Parameters:
//   ADDR_WIDTH  byte-address width; RAM depth is 2**ADDR_WIDTH bytes.
//
// Ports:
//   clk         in   1           rising-edge clock
//   reset       in   1           synchronous, active-high reset
//   mem_enable  in   1           request strobe, only looked at in IDLE
//   mem_rw      in   1           1 = store, 0 = load
//   mem_size    in   1           1 = byte, 0 = word
//   mem_addr    in   ADDR_WIDTH  byte address
//   mem_wdata   in   32          store data (byte store uses [7:0])
//   mem_rdata   out  32          load result, held until the next load ends
//   busy        out  1           access in flight
//   done        out  1           one-cycle completion pulse
//   err         out  1           misaligned word access, valid with done
//
// Configuration:
//   DMEM_ALIGN_CHECK_EN  when defined, a word request whose addr[1:0] != 0 goes
//                        straight from IDLE to DONE with err = 1 and touches
//                        neither the RAM nor mem_rdata. When undefined, err is
//                        0 and a misaligned word simply wraps through
//                        addr..addr+3.
// -----------------------------------------------------------------------------
module data_mem_unit #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_enable,
  input  logic                  mem_rw,
  input  logic                  mem_size,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // State and latched request.
  state_t                r_state;
  state_t                w_next_state;
  logic                  r_rw;
  logic                  r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [1:0]            r_cnt;
  logic [31:0]           r_asm;
  logic [31:0]           r_rdata;

  // Byte-wide RAM.
  logic [7:0]            r_mem [DEPTH];

  // Datapath wires.
  logic [ADDR_WIDTH-1:0] w_byte_addr;
  logic [7:0]            w_rbyte;
  logic [7:0]            w_wbyte;
  logic [31:0]           w_asm_next;
  logic                  w_last;
  logic                  w_we;
  logic                  w_misaligned;

  // ---------------------------------------------------------------------------
  // Alignment check on the incoming request (only meaningful in IDLE).
  // ---------------------------------------------------------------------------
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misaligned = !mem_size && (mem_addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Byte lane selection. Address wraps naturally at ADDR_WIDTH bits.
  // ---------------------------------------------------------------------------
  assign w_byte_addr = r_addr + ADDR_WIDTH'(r_cnt);
  assign w_rbyte     = r_mem[w_byte_addr];
  assign w_last      = r_size || (r_cnt == 2'd3);

  // A byte access always lives in lane [7:0]; a word access walks the lanes
  // from most significant (cnt 0) to least significant (cnt 3).
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_asm_next = r_asm;
    w_wbyte    = r_wdata[7:0];
    if (r_size) begin
      w_asm_next = {24'b0, w_rbyte};
    end else begin
      case (r_cnt)
        2'd0: begin
          w_asm_next[31:24] = w_rbyte;
          w_wbyte           = r_wdata[31:24];
        end
        2'd1: begin
          w_asm_next[23:16] = w_rbyte;
          w_wbyte           = r_wdata[23:16];
        end
        2'd2: begin
          w_asm_next[15:8] = w_rbyte;
          w_wbyte          = r_wdata[15:8];
        end
        2'd3: begin
          w_asm_next[7:0] = w_rbyte;
          w_wbyte         = r_wdata[7:0];
        end
      endcase
    end
  end

  // Gate the write with reset so the byte that would land on the reset edge
  // of an aborted store is not written.
  assign w_we = (r_state == S_ACCESS) && r_rw && !reset;

  // ---------------------------------------------------------------------------
  // FSM: state register.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_enable) begin
          w_next_state = w_misaligned ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch, byte counter, load assembly and result register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rw    <= 1'b0;
      r_size  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= 2'd0;
      r_asm   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_enable) begin
            r_rw    <= mem_rw;
            r_size  <= mem_size;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_cnt   <= 2'd0;
            r_asm   <= '0;
          end
        end
        S_ACCESS: begin
          r_asm <= w_asm_next;
          r_cnt <= r_cnt + 2'd1;
          // The last byte is merged in the same edge so mem_rdata is already
          // complete in the DONE cycle. Stores leave mem_rdata alone.
          if (w_last && !r_rw) begin
            r_rdata <= w_asm_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port.
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array has no reset; contents survive reset and a reset
  // branch here would prevent mapping onto a real memory.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_byte_addr] <= w_wbyte;
    end
  end

  // ---------------------------------------------------------------------------
  // Error flag.
  // ---------------------------------------------------------------------------
`ifdef DMEM_ALIGN_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && mem_enable) begin
      r_err <= w_misaligned;
    end
  end

  assign err = (r_state == S_DONE) && r_err;
`else
  assign err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: registered or decoded from state only.
  // ---------------------------------------------------------------------------
  assign mem_rdata = r_rdata;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_data_mem_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_data_mem_unit
//
// Directed bench for data_mem_unit. A table of requests with hand-computed
// results (read data, latency counted from the accepting cycle, err) is applied
// in a loop, followed by hand-written sequences for reset values, a held
// mem_enable and a reset in the middle of a word store.
// -----------------------------------------------------------------------------
module tb_data_mem_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_enable;
  logic          mem_rw;
  logic          mem_size;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rw;
    logic        size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  data_mem_unit #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_enable (mem_enable),
    .mem_rw     (mem_rw),
    .mem_size   (mem_size),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic size,
                              input logic [7:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input int exp_lat,
                              input logic exp_err);
    vec_t v;
    v.rw        = rw;
    v.size      = size;
    v.addr      = addr;
    v.wdata     = wdata;
    v.exp_rdata = exp_rdata;
    v.exp_lat   = exp_lat;
    v.exp_err   = exp_err;
    return v;
  endfunction

  // Presents one request, checks it was accepted, then waits (bounded) for
  // done. lat counts cycles from the accepting cycle (1) to the done cycle.
  task automatic do_req(input string tag, input logic rw, input logic size,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        output int lat);
    @(negedge clk);
    mem_enable = 1'b1;
    mem_rw     = rw;
    mem_size   = size;
    mem_addr   = addr;
    mem_wdata  = wdata;
    @(posedge clk);
    #1;
    mem_enable = 1'b0;
    check({tag, " busy after accept"}, 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;

    reset      = 1'b1;
    mem_enable = 1'b0;
    mem_rw     = 1'b0;
    mem_size   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",  32'(busy),  32'd0);
    check("reset done",  32'(done),  32'd0);
    check("reset err",   32'(err),   32'd0);
    check("reset rdata", mem_rdata,  32'h0);
    reset = 1'b0;

    // Request table: rw, size(1=byte), addr, wdata, rdata, latency, err.
    vecs.push_back(mk(1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 32'h00000000, 5, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 5, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'h11, 32'h123456A5, 32'hDEADBEEF, 2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h10, 32'h0,        32'hDEA5BEEF, 5, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h11, 32'h0,        32'h000000A5, 2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h12, 32'h0,        32'h000000BE, 2, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h20, 32'hAABBCCDD, 32'h000000BE, 5, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'h30, 32'hFFFFFF5A, 32'h000000BE, 2, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'h31, 32'h0000006B, 32'h000000BE, 2, 1'b0));
`ifdef DMEM_ALIGN_CHECK_EN
    vecs.push_back(mk(1'b0, 1'b0, 8'h12, 32'h0,        32'h000000BE, 1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 8'h11, 32'h01020304, 32'h000000BE, 1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h10, 32'h0,        32'hDEA5BEEF, 5, 1'b0));
`else
    vecs.push_back(mk(1'b1, 1'b0, 8'hFE, 32'hCAFEF00D, 32'h000000BE, 5, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 32'h0,        32'h000000FE, 2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 32'h0,        32'h000000F0, 2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h01, 32'h0,        32'h0000000D, 2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFE, 32'h0,        32'hCAFEF00D, 5, 1'b0));
`endif

    foreach (vecs[i]) begin
      do_req($sformatf("v%0d", i), vecs[i].rw, vecs[i].size, vecs[i].addr,
             vecs[i].wdata, lat);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d rdata", i), mem_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].exp_err));
      @(posedge clk);
      #1;
      check($sformatf("v%0d idle busy", i), 32'(busy), 32'd0);
      check($sformatf("v%0d done pulse", i), 32'(done), 32'd0);
    end

    // Held mem_enable: the address changes right after acceptance; the second
    // request must only be taken on the first edge seen in IDLE.
    @(negedge clk);
    mem_enable = 1'b1;
    mem_rw     = 1'b0;
    mem_size   = 1'b1;
    mem_addr   = 8'h30;
    @(posedge clk); #1;                      // accepted, ACCESS
    check("hold accept busy", 32'(busy), 32'd1);
    mem_addr = 8'h31;
    @(posedge clk); #1;                      // DONE
    check("hold first done",  32'(done), 32'd1);
    check("hold first rdata", mem_rdata, 32'h0000005A);
    @(posedge clk); #1;                      // IDLE, not accepted in DONE
    check("hold idle busy",   32'(busy), 32'd0);
    @(posedge clk); #1;                      // second request accepted
    check("hold second busy", 32'(busy), 32'd1);
    check("hold second done", 32'(done), 32'd0);
    @(posedge clk); #1;                      // DONE
    mem_enable = 1'b0;
    check("hold second done2", 32'(done), 32'd1);
    check("hold second rdata", mem_rdata, 32'h0000006B);
    @(posedge clk); #1;
    check("hold end busy", 32'(busy), 32'd0);

    // Reset after two bytes of a word store to 0x20 (which holds AABBCCDD).
    @(negedge clk);
    mem_enable = 1'b1;
    mem_rw     = 1'b1;
    mem_size   = 1'b0;
    mem_addr   = 8'h20;
    mem_wdata  = 32'h11223344;
    @(posedge clk); #1;                      // accepted
    mem_enable = 1'b0;
    check("abort accept busy", 32'(busy), 32'd1);
    @(posedge clk); #1;                      // byte 0 written
    check("abort done0", 32'(done), 32'd0);
    @(posedge clk); #1;                      // byte 1 written
    check("abort done1", 32'(done), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;                      // reset edge
    check("abort busy",  32'(busy), 32'd0);
    check("abort done",  32'(done), 32'd0);
    check("abort err",   32'(err),  32'd0);
    check("abort rdata", mem_rdata, 32'h0);
    reset = 1'b0;

    do_req("post-abort", 1'b0, 1'b0, 8'h20, 32'h0, lat);
    check("post-abort latency", 32'(lat), 32'd5);
    check("post-abort rdata", mem_rdata, 32'h1122CCDD);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
